spu_result_pipe: RTL and testbench



---
 rtl/spu_result_pipe.sv | 118 +++++++++++
 tb/tb_spu_result_pipe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_result_pipe.sv
// spu_result_pipe: per-lane latency-aligned result staging with register
// busy/forwarding lookups, global flush and registered error pulses.
module spu_result_pipe #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 7,
  parameter int DATA_W = 128,
  parameter int REG_W  = 7,
  parameter int UNIT_W = 3,
  parameter int LAT_W  = 3,
  parameter int NQ     = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES-1:0]        in_we_i,
  input  logic [LANES*DATA_W-1:0] in_result_i,
  input  logic [LANES*REG_W-1:0]  in_rt_i,
  input  logic [LANES*UNIT_W-1:0] in_unit_i,
  input  logic [LANES*LAT_W-1:0]  in_lat_i,
  input  logic                    flush_i,
  output logic [LANES-1:0]        wb_we_o,
  output logic [LANES*DATA_W-1:0] wb_result_o,
  output logic [LANES*REG_W-1:0]  wb_rt_o,
  output logic [LANES*UNIT_W-1:0] wb_unit_o,
  input  logic [NQ*REG_W-1:0]     q_rt_i,
  output logic [NQ-1:0]           q_busy_o,
  output logic [NQ-1:0]           q_hit_o,
  output logic [NQ*DATA_W-1:0]    q_data_o,
  output logic                    lat_err_o,
  output logic                    col_err_o
);
  logic [LANES-1:0]    ill, col;
  logic [LANES*NQ-1:0] busy_f, hit_f;
  logic                lat_err_q, lat_err_d, col_err_q, col_err_d;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DEPTH-1:0]  vld_q, vld_d, ins;
    logic [DATA_W-1:0] res_q [DEPTH];
    logic [DATA_W-1:0] res_d [DEPTH];
    logic [REG_W-1:0]  rt_q [DEPTH];
    logic [REG_W-1:0]  rt_d [DEPTH];
    logic [UNIT_W-1:0] unit_q [DEPTH];
    logic [UNIT_W-1:0] unit_d [DEPTH];
    logic [LAT_W-1:0]  lat;
    logic              legal;
    logic [NQ-1:0]     busy, hit;
    assign lat    = in_lat_i[i*LAT_W +: LAT_W];
    assign legal  = in_we_i[i] && lat != '0 && int'(lat) <= DEPTH;
    assign ill[i] = in_we_i[i] && !legal;
    // an insert at stage s overwrites whatever is shifting in from s-1
    assign col[i] = |(ins[DEPTH-1:1] & vld_q[DEPTH-2:0]);
    always_comb begin
      for (int k = 0; k < DEPTH; k++) ins[k] = legal && int'(lat) == DEPTH - k;
      vld_d = flush_i ? '0 : {vld_q[DEPTH-2:0], 1'b0} | ins;
      for (int k = 0; k < DEPTH; k++) begin
        res_d[k]  = ins[k] ? in_result_i[i*DATA_W +: DATA_W] : res_q[k == 0 ? 0 : k-1];
        rt_d[k]   = ins[k] ? in_rt_i[i*REG_W +: REG_W] : rt_q[k == 0 ? 0 : k-1];
        unit_d[k] = ins[k] ? in_unit_i[i*UNIT_W +: UNIT_W] : unit_q[k == 0 ? 0 : k-1];
      end
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= '0;
        res_q  <= '{default: '0};
        rt_q   <= '{default: '0};
        unit_q <= '{default: '0};
      end else begin
        vld_q  <= vld_d;
        res_q  <= res_d;
        rt_q   <= rt_d;
        unit_q <= unit_d;
      end
    end
    always_comb begin
      busy = '0;
      for (int q = 0; q < NQ; q++) begin
        for (int k = 0; k < DEPTH; k++)
          if (vld_q[k] && rt_q[k] == q_rt_i[q*REG_W +: REG_W]) busy[q] = 1'b1;
        hit[q] = vld_q[DEPTH-1] && rt_q[DEPTH-1] == q_rt_i[q*REG_W +: REG_W];
      end
    end
    assign busy_f[i*NQ +: NQ]               = busy;
    assign hit_f[i*NQ +: NQ]                = hit;
    assign wb_we_o[i]                       = vld_q[DEPTH-1];
    assign wb_result_o[i*DATA_W +: DATA_W]  = res_q[DEPTH-1];
    assign wb_rt_o[i*REG_W +: REG_W]        = rt_q[DEPTH-1];
    assign wb_unit_o[i*UNIT_W +: UNIT_W]    = unit_q[DEPTH-1];
  end

  // later lanes overwrite earlier ones, so the highest hitting lane forwards
  always_comb begin
    lat_err_d = !flush_i && |ill;
    col_err_d = !flush_i && |col;
    q_busy_o  = '0;
    q_hit_o   = '0;
    q_data_o  = '0;
    for (int i = 0; i < LANES; i++)
      for (int q = 0; q < NQ; q++) begin
        q_busy_o[q] = q_busy_o[q] | busy_f[i*NQ+q];
        if (hit_f[i*NQ+q]) begin
          q_hit_o[q]                   = 1'b1;
          q_data_o[q*DATA_W +: DATA_W] = wb_result_o[i*DATA_W +: DATA_W];
        end
      end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_err_q <= 1'b0;
      col_err_q <= 1'b0;
    end else begin
      lat_err_q <= lat_err_d;
      col_err_q <= col_err_d;
    end
  end

  assign lat_err_o = lat_err_q;
  assign col_err_o = col_err_q;
endmodule

// File: tb/tb_spu_result_pipe.sv
// tb_spu_result_pipe: directed and randomized checks of spu_result_pipe against
// a record-list model where each entry simply carries its due writeback cycle.
module tb_spu_result_pipe;
  localparam int LANES = 2, DEPTH = 7, DATA_W = 128, REG_W = 7, UNIT_W = 3, LAT_W = 3, NQ = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [LANES-1:0]        in_we;
  logic [LANES*DATA_W-1:0] in_result;
  logic [LANES*REG_W-1:0]  in_rt;
  logic [LANES*UNIT_W-1:0] in_unit;
  logic [LANES*LAT_W-1:0]  in_lat;
  logic                    flush;
  logic [NQ*REG_W-1:0]     q_rt;
  logic [LANES-1:0]        wb_we, wb_we6;
  logic [LANES*DATA_W-1:0] wb_result, wb_result6;
  logic [LANES*REG_W-1:0]  wb_rt, wb_rt6;
  logic [LANES*UNIT_W-1:0] wb_unit, wb_unit6;
  logic [NQ-1:0]           q_busy, q_hit, q_busy6, q_hit6;
  logic [NQ*DATA_W-1:0]    q_data, q_data6;
  logic                    lat_err, col_err, lat_err6, col_err6;

  always #5 clk = ~clk;

  spu_result_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_we_i(in_we), .in_result_i(in_result), .in_rt_i(in_rt),
    .in_unit_i(in_unit), .in_lat_i(in_lat), .flush_i(flush), .wb_we_o(wb_we),
    .wb_result_o(wb_result), .wb_rt_o(wb_rt), .wb_unit_o(wb_unit), .q_rt_i(q_rt),
    .q_busy_o(q_busy), .q_hit_o(q_hit), .q_data_o(q_data), .lat_err_o(lat_err),
    .col_err_o(col_err));

  spu_result_pipe #(.DEPTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_we_i(in_we), .in_result_i(in_result), .in_rt_i(in_rt),
    .in_unit_i(in_unit), .in_lat_i(in_lat), .flush_i(flush), .wb_we_o(wb_we6),
    .wb_result_o(wb_result6), .wb_rt_o(wb_rt6), .wb_unit_o(wb_unit6), .q_rt_i(q_rt),
    .q_busy_o(q_busy6), .q_hit_o(q_hit6), .q_data_o(q_data6), .lat_err_o(lat_err6),
    .col_err_o(col_err6));

  typedef struct {
    int                lane;
    longint            due;
    logic [REG_W-1:0]  rt;
    logic [DATA_W-1:0] data;
    logic [UNIT_W-1:0] unit;
  } rec_t;

  rec_t   recs[$];
  longint cyc;
  logic   m_lat, m_col, m_lat6;
  int     n_pass = 0, n_total = 0;
  int     l;

  // Model: a result is due latency cycles after issue; one result per lane per due cycle, newest wins.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      recs.delete();
      m_lat = 0; m_col = 0; m_lat6 = 0; cyc = 0;
    end else begin
      for (int j = recs.size() - 1; j >= 0; j--) if (recs[j].due == cyc) recs.delete(j);
      m_lat = 0; m_col = 0; m_lat6 = 0;
      if (flush) recs.delete();
      else for (int i = 0; i < LANES; i++) if (in_we[i]) begin
        l = int'(in_lat[i*LAT_W +: LAT_W]);
        if (l == 0 || l > 6) m_lat6 = 1;
        if (l == 0 || l > DEPTH) m_lat = 1;
        else begin
          for (int j = recs.size() - 1; j >= 0; j--)
            if (recs[j].lane == i && recs[j].due == cyc + l) begin recs.delete(j); m_col = 1; end
          recs.push_back('{i, cyc + l, in_rt[i*REG_W +: REG_W], in_result[i*DATA_W +: DATA_W],
                           in_unit[i*UNIT_W +: UNIT_W]});
        end
      end
      cyc++;
    end
  end

  function automatic logic e_we(int ln);
    foreach (recs[j]) if (recs[j].lane == ln && recs[j].due == cyc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic rec_t e_wb(int ln);
    rec_t r = '{0, 0, '0, '0, '0};
    foreach (recs[j]) if (recs[j].lane == ln && recs[j].due == cyc) r = recs[j];
    return r;
  endfunction

  function automatic logic e_busy(logic [REG_W-1:0] r);
    foreach (recs[j]) if (recs[j].rt == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic e_hit(logic [REG_W-1:0] r);
    foreach (recs[j]) if (recs[j].due == cyc && recs[j].rt == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DATA_W-1:0] e_qdata(logic [REG_W-1:0] r);
    logic [DATA_W-1:0] d = '0;
    for (int ln = 0; ln < LANES; ln++)
      foreach (recs[j]) if (recs[j].lane == ln && recs[j].due == cyc && recs[j].rt == r) d = recs[j].data;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_we = '0; flush = 1'b0;
  endtask

  task automatic issue(int ln, int lat, logic [REG_W-1:0] rt, logic [DATA_W-1:0] d, logic [UNIT_W-1:0] u);
    in_we[ln] = 1'b1;
    in_lat[ln*LAT_W +: LAT_W]      = LAT_W'(lat);
    in_rt[ln*REG_W +: REG_W]       = rt;
    in_result[ln*DATA_W +: DATA_W] = d;
    in_unit[ln*UNIT_W +: UNIT_W]   = u;
  endtask

  task automatic test_reset();
    n_total++; if ({wb_we, wb_rt, wb_unit, q_busy, q_hit, lat_err, col_err} !== '0)
      $display("FAIL reset_ctrl: got %0h required 0", {wb_we, wb_rt, wb_unit, q_busy, q_hit, lat_err, col_err});
      else n_pass++;
    n_total++; if ({wb_result, q_data} !== '0) $display("FAIL reset_data: got nonzero required 0"); else n_pass++;
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] d = {16{8'hA5}};
    idle(); issue(0, 1, 7'd5, d, 3'd3); q_rt = {7'd0, 7'd0, 7'd5};
    tick(); idle();
    n_total++; if (wb_we !== 2'b01) $display("FAIL single_l1_we: got %b required 01", wb_we); else n_pass++;
    n_total++; if (wb_rt[0 +: REG_W] !== 7'd5) $display("FAIL single_l1_rt: got %0d required 5", wb_rt[0 +: REG_W]); else n_pass++;
    n_total++; if (wb_result[0 +: DATA_W] !== d) $display("FAIL single_l1_data: got %h required %h", wb_result[0 +: DATA_W], d); else n_pass++;
    n_total++; if (wb_unit[0 +: UNIT_W] !== 3'd3) $display("FAIL single_l1_unit: got %0d required 3", wb_unit[0 +: UNIT_W]); else n_pass++;
    n_total++; if (q_hit[0] !== 1'b1 || q_data[0 +: DATA_W] !== d) $display("FAIL single_l1_fwd: hit %b data %h required 1 %h", q_hit[0], q_data[0 +: DATA_W], d); else n_pass++;
    tick();
    n_total++; if (wb_we !== 2'b00) $display("FAIL single_l1_once: got %b required 00", wb_we); else n_pass++;
    issue(0, 7, 7'd5, ~d, 3'd1);
    for (int c = 1; c <= 8; c++) begin
      tick(); idle();
      n_total++; if (q_busy[0] !== (c <= 7)) $display("FAIL single_l7_busy c=%0d: got %b required %b", c, q_busy[0], c <= 7); else n_pass++;
      n_total++; if (wb_we[0] !== (c == 7)) $display("FAIL single_l7_we c=%0d: got %b required %b", c, wb_we[0], c == 7); else n_pass++;
    end
  endtask

  task automatic test_collision();
    logic [DATA_W-1:0] dx = 128'h1111, dy = 128'h2222;
    idle(); issue(0, 6, 7'd20, dx, 3'd2); q_rt = {7'd0, 7'd21, 7'd20};
    tick(); idle();
    for (int c = 1; c < 4; c++) tick();
    issue(0, 2, 7'd21, dy, 3'd4);
    tick(); idle();
    n_total++; if (col_err !== 1'b1) $display("FAIL coll_err: got %b required 1", col_err); else n_pass++;
    n_total++; if (q_busy[0] !== 1'b0) $display("FAIL coll_lost_busy: got %b required 0", q_busy[0]); else n_pass++;
    tick();
    n_total++; if (wb_we[0] !== 1'b1 || wb_result[0 +: DATA_W] !== dy || wb_rt[0 +: REG_W] !== 7'd21)
      $display("FAIL coll_wb: we %b rt %0d data %h required 1 21 %h", wb_we[0], wb_rt[0 +: REG_W], wb_result[0 +: DATA_W], dy); else n_pass++;
    n_total++; if (col_err !== 1'b0) $display("FAIL coll_err_pulse: got %b required 0", col_err); else n_pass++;
    tick();
    n_total++; if (wb_we !== 2'b00) $display("FAIL coll_old_never: got %b required 00", wb_we); else n_pass++;
  endtask

  task automatic test_both_lanes();
    logic [DATA_W-1:0] da = 128'hAAAA_0000, db = 128'hBBBB_0001;
    idle(); issue(0, 3, 7'd9, da, 3'd1); issue(1, 3, 7'd9, db, 3'd2);
    tick(); idle(); tick(); tick();
    q_rt = {7'd0, 7'd10, 7'd9}; #1;
    n_total++; if (wb_we !== 2'b11) $display("FAIL both_we: got %b required 11", wb_we); else n_pass++;
    n_total++; if (q_hit[0] !== 1'b1 || q_data[0 +: DATA_W] !== db) $display("FAIL both_fwd_hi_lane: hit %b data %h required 1 %h", q_hit[0], q_data[0 +: DATA_W], db); else n_pass++;
    n_total++; if (q_busy[1] !== 1'b0 || q_hit[1] !== 1'b0 || q_data[DATA_W +: DATA_W] !== '0)
      $display("FAIL both_miss: busy %b hit %b data %h required 0 0 0", q_busy[1], q_hit[1], q_data[DATA_W +: DATA_W]); else n_pass++;
  endtask

  task automatic test_lat_err();
    logic seen6 = 1'b0;
    idle(); for (int c = 0; c < 9; c++) tick();
    issue(0, 0, 7'd30, 128'h3, 3'd0);
    tick(); idle();
    n_total++; if (lat_err !== 1'b1 || lat_err6 !== 1'b1) $display("FAIL lat0_err: got %b/%b required 1/1", lat_err, lat_err6); else n_pass++;
    tick();
    n_total++; if (lat_err !== 1'b0) $display("FAIL lat0_err_pulse: got %b required 0", lat_err); else n_pass++;
    issue(0, 7, 7'd31, 128'h4, 3'd0);
    tick(); idle();
    n_total++; if (lat_err6 !== 1'b1 || lat_err !== 1'b0) $display("FAIL lat7_err: got d6 %b d7 %b required 1 0", lat_err6, lat_err); else n_pass++;
    for (int c = 0; c < 9; c++) begin
      if (c == 1) begin
        n_total++; if (lat_err6 !== 1'b0) $display("FAIL lat7_err_pulse: got %b required 0", lat_err6); else n_pass++;
      end
      seen6 |= |wb_we6;
      tick();
    end
    n_total++; if (seen6 !== 1'b0) $display("FAIL lat_no_wb: got %b required 0", seen6); else n_pass++;
  endtask

  task automatic test_flush();
    idle();
    for (int k = 1; k <= 7; k++) begin
      idle(); issue(0, k, 7'(40 + k), 128'(k), 3'd5);
      tick();
    end
    idle(); issue(0, 2, 7'd50, 128'h50, 3'd6); issue(1, 0, 7'd51, 128'h51, 3'd6); flush = 1'b1;
    q_rt = {7'd47, 7'd46, 7'd45}; #1;
    n_total++; if (q_busy !== 3'b111) $display("FAIL flush_pre_busy: got %b required 111", q_busy); else n_pass++;
    tick(); idle();
    n_total++; if (q_busy !== 3'b000 || wb_we !== 2'b00) $display("FAIL flush_clear: busy %b we %b required 000 00", q_busy, wb_we); else n_pass++;
    n_total++; if (lat_err !== 1'b0 || col_err !== 1'b0) $display("FAIL flush_err: got %b%b required 00", lat_err, col_err); else n_pass++;
    q_rt = {7'd50, 7'd50, 7'd50};
    tick();
    n_total++; if (wb_we !== 2'b00 || q_busy !== 3'b000) $display("FAIL flush_dropped: we %b busy %b required 00 000", wb_we, q_busy); else n_pass++;
  endtask

  task automatic test_async_reset();
    idle(); issue(0, 2, 7'd61, 128'h61, 3'd1);
    tick(); idle(); issue(0, 4, 7'd60, 128'h60, 3'd2); issue(1, 0, 7'd0, 128'h0, 3'd0);
    tick(); idle();
    q_rt = {7'd0, 7'd61, 7'd60}; #1;
    n_total++; if (wb_we[0] !== 1'b1 || q_busy[1:0] !== 2'b11 || lat_err !== 1'b1)
      $display("FAIL areset_pre: we %b busy %b lat %b required 1 11 1", wb_we[0], q_busy[1:0], lat_err); else n_pass++;
    rst_n = 1'b0; #1;
    n_total++; if (wb_we !== 2'b00 || q_busy !== 3'b000 || lat_err !== 1'b0 || col_err !== 1'b0)
      $display("FAIL areset_drop: we %b busy %b err %b%b required 0", wb_we, q_busy, lat_err, col_err); else n_pass++;
    tick(); rst_n = 1'b1;
    issue(0, 2, 7'd62, 128'hCAFE, 3'd7);
    tick(); idle(); tick();
    n_total++; if (wb_we !== 2'b01 || wb_rt[0 +: REG_W] !== 7'd62 || wb_result[0 +: DATA_W] !== 128'hCAFE)
      $display("FAIL areset_after: we %b rt %0d data %h required 01 62 cafe", wb_we, wb_rt[0 +: REG_W], wb_result[0 +: DATA_W]); else n_pass++;
  endtask

  task automatic test_random();
    rec_t r;
    for (int c = 0; c < 400; c++) begin
      for (int q = 0; q < NQ; q++) q_rt[q*REG_W +: REG_W] = REG_W'($urandom_range(0, 15));
      #1;
      for (int i = 0; i < LANES; i++) begin
        r = e_wb(i);
        n_total++; if (wb_we[i] !== e_we(i)) $display("FAIL rnd_we c=%0d lane %0d: got %b required %b", c, i, wb_we[i], e_we(i)); else n_pass++;
        if (e_we(i)) begin
          n_total++; if (wb_rt[i*REG_W +: REG_W] !== r.rt || wb_unit[i*UNIT_W +: UNIT_W] !== r.unit || wb_result[i*DATA_W +: DATA_W] !== r.data)
            $display("FAIL rnd_wb c=%0d lane %0d: rt %0d unit %0d data %h required %0d %0d %h", c, i,
                     wb_rt[i*REG_W +: REG_W], wb_unit[i*UNIT_W +: UNIT_W], wb_result[i*DATA_W +: DATA_W], r.rt, r.unit, r.data);
            else n_pass++;
        end
      end
      for (int q = 0; q < NQ; q++) begin
        n_total++; if (q_busy[q] !== e_busy(q_rt[q*REG_W +: REG_W]) || q_hit[q] !== e_hit(q_rt[q*REG_W +: REG_W]) ||
                       q_data[q*DATA_W +: DATA_W] !== e_qdata(q_rt[q*REG_W +: REG_W]))
          $display("FAIL rnd_q c=%0d q%0d: busy %b hit %b data %h required %b %b %h", c, q, q_busy[q], q_hit[q],
                   q_data[q*DATA_W +: DATA_W], e_busy(q_rt[q*REG_W +: REG_W]), e_hit(q_rt[q*REG_W +: REG_W]), e_qdata(q_rt[q*REG_W +: REG_W]));
          else n_pass++;
      end
      n_total++; if (lat_err !== m_lat || col_err !== m_col) $display("FAIL rnd_err c=%0d: got %b%b required %b%b", c, lat_err, col_err, m_lat, m_col); else n_pass++;
      idle();
      for (int i = 0; i < LANES; i++)
        if ($urandom_range(0, 9) < 6)
          issue(i, int'($urandom_range(0, 7)), REG_W'($urandom_range(0, 15)),
                {$urandom(), $urandom(), $urandom(), $urandom()}, UNIT_W'($urandom_range(0, 7)));
      flush = ($urandom_range(0, 24) == 0);
      @(posedge clk); #1;
    end
    idle();
  endtask

  initial begin
    in_we = '0; in_result = '0; in_rt = '0; in_unit = '0; in_lat = '0; flush = 1'b0; q_rt = '0;
    #1;
    test_reset();
    tick(); tick(); rst_n = 1'b1;
    test_single();
    test_collision();
    test_both_lanes();
    test_lat_err();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
